// File: rtl/mem_map_pkg.sv
// Shared CPU data-memory map: I/O register addresses, RAM offset, widths and
// the read-port FSM state type.
package mem_map_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WAIT_W = 4;

  localparam logic [ADDR_W-1:0] SW_ADDR    = 16'hBF00;
  localparam logic [ADDR_W-1:0] STAT_ADDR  = 16'hBF01;
  // Same address as SW_ADDR; the write path drives LEDs there.
  localparam logic [ADDR_W-1:0] LED_ADDR   = 16'hBF00;
  localparam logic [ADDR_W-1:0] RAM_OFFSET = 16'h0080;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAM_SETUP = 2'd1,
    ST_RAM_WAIT  = 2'd2,
    ST_RESP      = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sw_sync_detect.sv
// Board switch synchroniser with sticky change flag.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   sw_in       - asynchronous switch pins
//   clr         - clears sw_changed (a same-cycle change wins)
//   sw_sync     - switches after a two-flop synchroniser
//   sw_changed  - set when sw_sync differs from its previous value
module sw_sync_detect
  import mem_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              clr,
  output logic [DATA_W-1:0] sw_sync,
  output logic              sw_changed
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] last_q;
  logic              changed_q;

  // Synchroniser, history register and sticky flag (set has priority).
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      last_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      meta_q <= sw_in;
      sync_q <= meta_q;
      last_q <= sync_q;
      if (sync_q != last_q) begin
        changed_q <= 1'b1;
      end else if (clr) begin
        changed_q <= 1'b0;
      end
    end
  end

  assign sw_sync    = sync_q;
  assign sw_changed = changed_q;

endmodule

// File: rtl/data_mem_read_port.sv
// CPU data-memory read port: decodes load addresses to external RAM (offset,
// multi-cycle access with output enable) or the switch / status I/O registers
// and returns the result with a one-cycle rd_valid pulse.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   rd_req       - load request, accepted only when idle
//   address      - load address, captured on acceptance
//   rd_data      - load result, held until the next rd_valid
//   rd_valid     - one-cycle result strobe
//   busy         - access in flight (or result being returned)
//   ram_addr     - registered RAM address (address + RAM_OFFSET)
//   ram_oe_n     - RAM output enable, active low
//   ram_data_in  - RAM read data
//   sw_in        - asynchronous board switches
module data_mem_read_port #(
  parameter logic [15:0] RAM_OFFSET = mem_map_pkg::RAM_OFFSET,
  parameter int unsigned RAM_WAIT   = 2,
  parameter logic [15:0] SW_ADDR    = mem_map_pkg::SW_ADDR,
  parameter logic [15:0] STAT_ADDR  = mem_map_pkg::STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [15:0] address,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [15:0] ram_addr,
  output logic        ram_oe_n,
  input  logic [15:0] ram_data_in,
  input  logic [15:0] sw_in
);

  import mem_map_pkg::*;

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RAM_WAIT - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_oe_n_q, ram_oe_n_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              sw_clr_c;
  logic [DATA_W-1:0] sw_sync;
  logic              sw_changed;

  sw_sync_detect u_sw_sync_detect (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .clr        (sw_clr_c),
    .sw_sync    (sw_sync),
    .sw_changed (sw_changed)
  );

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_oe_n_q <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_oe_n_q <= ram_oe_n_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_oe_n_d = ram_oe_n_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    sw_clr_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          addr_d = address;
          if (address == SW_ADDR || address == STAT_ADDR) begin
            state_d = ST_RESP;
          end else begin
            // Offset wraps modulo 2^16 by truncation.
            ram_addr_d = address + RAM_OFFSET;
            state_d    = ST_RAM_SETUP;
          end
        end
      end
      ST_RAM_SETUP: begin
        ram_oe_n_d = 1'b0;
        cnt_d      = WAIT_INIT;
        state_d    = ST_RAM_WAIT;
      end
      ST_RAM_WAIT: begin
        if (cnt_q == '0) begin
          rd_data_d  = ram_data_in;
          ram_oe_n_d = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_RESP: begin
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
        if (addr_q == SW_ADDR) begin
          rd_data_d = sw_sync;
        end else begin
          // Status read clears the change flag.
          rd_data_d = {{(DATA_W-1){1'b0}}, sw_changed};
          sw_clr_c  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy covers the rd_valid cycle even though the FSM is already idle.
  assign busy     = (state_q != ST_IDLE) || rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ram_addr = ram_addr_q;
  assign ram_oe_n = ram_oe_n_q;

endmodule

// File: tb/tb_data_mem_read_port.sv
// Self-checking bench for data_mem_read_port: directed cases plus a random
// mix of RAM, switch and status reads against a transaction-level model.
module tb_data_mem_read_port;

  localparam int unsigned RAM_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [15:0] address;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [15:0] ram_addr;
  logic        ram_oe_n;
  logic [15:0] ram_data_in;
  logic [15:0] sw_in;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current switch value and whether a change is pending since the
  // last status read (switches are only changed while no read is in flight,
  // followed by a settle period).
  logic [15:0] sw_model;
  bit          chg_model;

  data_mem_read_port #(
    .RAM_OFFSET (16'h0080),
    .RAM_WAIT   (RAM_WAIT),
    .SW_ADDR    (16'hBF00),
    .STAT_ADDR  (16'hBF01)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .address     (address),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_oe_n    (ram_oe_n),
    .ram_data_in (ram_data_in),
    .sw_in       (sw_in)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sw(input logic [15:0] v);
    sw_in = v;
    if (v != sw_model) chg_model = 1'b1;
    sw_model = v;
    step(4);
  endtask

  // One load; latency is the edge (counted from acceptance) at which the CPU
  // samples rd_valid high: 2 for I/O, RAM_WAIT+2 for RAM.
  task automatic do_read(input logic [15:0] addr, input logic [15:0] exp_data, input bit is_ram);
    int first_k = 0;
    int pulses  = 0;
    int oe_low  = 0;
    int exp_lat;
    logic [15:0] exp_ram_addr;
    exp_lat      = is_ram ? int'(RAM_WAIT) + 2 : 2;
    exp_ram_addr = addr + 16'h0080;
    address = addr;
    rd_req  = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (!ram_oe_n) oe_low++;
      if (k == 1 && is_ram) check_eq("ram_addr", 32'(ram_addr), 32'(exp_ram_addr));
      if (first_k != 0 && k == first_k + 1) check_eq("busy_after_valid", 32'(busy), 32'd0);
      if (rd_valid) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          check_eq("rd_data", 32'(rd_data), 32'(exp_data));
          check_eq("busy_in_valid", 32'(busy), 32'd1);
        end
      end
    end
    check_eq("latency", (first_k == 0) ? 32'd0 : 32'(first_k + 1), 32'(exp_lat));
    check_eq("valid_pulses", 32'(pulses), 32'd1);
    check_eq("oe_low_cycles", 32'(oe_low), is_ram ? 32'(RAM_WAIT) : 32'd0);
    check_eq("rd_data_hold", 32'(rd_data), 32'(exp_data));
  endtask

  initial begin
    int pulses;
    logic [15:0] a;
    logic [15:0] d;

    rst = 1'b1; rd_req = 1'b0; address = '0; ram_data_in = '0; sw_in = '0;
    sw_model = '0; chg_model = 1'b0;
    step(3);
    rst = 1'b0;

    // Reset values hold while idle.
    for (int i = 0; i < 10; i++) begin
      check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("rst_oe_n", 32'(ram_oe_n), 32'd1);
      check_eq("rst_rd_data", 32'(rd_data), 32'd0);
      if (i == 0) begin
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
      end
      step(1);
    end

    // Directed RAM reads, including offset wrap.
    ram_data_in = 16'h1234;
    do_read(16'h0010, 16'h1234, 1'b1);
    ram_data_in = 16'h5A5A;
    do_read(16'hFFF0, 16'h5A5A, 1'b1);

    // Switch read after 3 cycles of stable input.
    sw_in = 16'hA5A5;
    if (sw_model != 16'hA5A5) chg_model = 1'b1;
    sw_model = 16'hA5A5;
    step(3);
    do_read(16'hBF00, 16'hA5A5, 1'b0);

    // Status sticky then cleared.
    set_sw(sw_model ^ 16'h0001);
    do_read(16'hBF01, 16'h0001, 1'b0);
    chg_model = 1'b0;
    do_read(16'hBF01, 16'h0000, 1'b0);

    // rd_req during the access is ignored.
    ram_data_in = 16'hBEEF;
    address = 16'h0200;
    rd_req  = 1'b1;
    step(1);
    address = 16'h0300;
    step(2);
    rd_req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_valid) pulses++;
      step(1);
    end
    check_eq("busy_ignore_pulses", 32'(pulses), 32'd1);
    check_eq("busy_ignore_data", 32'(rd_data), 32'h0000BEEF);
    check_eq("busy_ignore_addr", 32'(ram_addr), 32'h00000280);

    // Reset during RAM_WAIT aborts the access.
    ram_data_in = 16'hCAFE;
    address = 16'h0400;
    rd_req  = 1'b1;
    step(1);
    rd_req = 1'b0;
    step(2);
    check_eq("abort_oe_before", 32'(ram_oe_n), 32'd0);
    rst = 1'b1;
    step(1);
    check_eq("abort_oe_n", 32'(ram_oe_n), 32'd1);
    check_eq("abort_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("abort_rd_data", 32'(rd_data), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (rd_valid) pulses++;
      step(1);
    end
    check_eq("abort_no_valid", 32'(pulses), 32'd0);
    // Synchroniser restarts from zero, so a nonzero switch value looks like a change.
    chg_model = (sw_model != 16'h0000);
    step(4);

    // Random mix.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 16'($urandom);
          if (a == 16'hBF00 || a == 16'hBF01) a = 16'h1000;
          d = 16'($urandom);
          ram_data_in = d;
          do_read(a, d, 1'b1);
        end
        1: do_read(16'hBF00, sw_model, 1'b0);
        2: begin
          do_read(16'hBF01, {15'b0, chg_model}, 1'b0);
          chg_model = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 1) == 0) set_sw(sw_model);
          else set_sw(16'($urandom));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_read_port.md
Name: data_mem_read_port

Overview:
- Read-side counterpart of the CPU data-memory write path: services CPU load requests over a 16-bit address space.
- Decodes each address to one of three targets: external RAM with a fixed address offset and a multi-cycle access, memory-mapped switch input at 16'hBF00, or status register at 16'hBF01.
- Returns data with a valid pulse. Sits between the CPU MEM stage and the board RAM / switch pins.

Parameters:
- RAM_OFFSET, 16'h0080: added to the CPU address to form the RAM address, modulo 2^16.
- RAM_WAIT, 2: cycles ram_oe_n is held low before RAM data is sampled; legal range 1..15.
- SW_ADDR, 16'hBF00: address of the switch input register.
- STAT_ADDR, 16'hBF01: address of the status register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  CPU load request; sampled only in IDLE.
- address  in  16  CPU load address; captured when rd_req is accepted.
- rd_data  out  16  load result; holds its value until the next rd_valid.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
- busy  out  1  high from the cycle after acceptance through the rd_valid cycle.
- ram_addr  out  16  RAM address, registered.
- ram_oe_n  out  1  RAM output enable, active low.
- ram_data_in  in  16  RAM read data.
- sw_in  in  16  asynchronous board switches.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, busy=0, ram_addr=0, ram_oe_n=1, state=IDLE, wait counter=0, sw_sync stages=0, sw_last=0, sw_changed=0.
- Switch synchroniser: sw_in passes through two flops to give sw_sync. Every cycle, if sw_sync != sw_last, set sw_changed=1; sw_last <= sw_sync.
- FSM states: IDLE, RAM_SETUP, RAM_WAIT, RESP.
- IDLE:
  - rd_req=1 latches address into addr_q.
  - addr_q==SW_ADDR or addr_q==STAT_ADDR goes to RESP.
  - Any other address: ram_addr <= address+RAM_OFFSET (wraps, e.g. 16'hFFF0 -> 16'h0070); go to RAM_SETUP.
- RAM_SETUP: ram_oe_n <= 0; counter <= RAM_WAIT-1; go to RAM_WAIT.
- RAM_WAIT:
  - counter==0: rd_data <= ram_data_in, ram_oe_n <= 1, rd_valid <= 1, go to IDLE.
  - Otherwise decrement the counter.
- RESP: rd_valid <= 1; go to IDLE.
  - SW_ADDR: rd_data <= sw_sync.
  - STAT_ADDR: rd_data <= {15'b0, sw_changed}; clear sw_changed in the same cycle.
- Read-to-clear vs. change collision: if a STAT read clears sw_changed in the same cycle a new change is detected, set wins and the flag stays 1.
- rd_valid lasts exactly one cycle.
- rd_req while busy is ignored, not queued. The CPU must hold off until rd_valid.
- rd_req asserted in the same cycle rd_valid is high is accepted; the FSM is already in IDLE.
- Latency:
  - IO read: rd_valid 2 cycles after the acceptance edge.
  - RAM read: rd_valid RAM_WAIT+2 cycles after the acceptance edge (4 with the default).
- busy is combinational: high when state != IDLE, or when rd_valid is high.
- Reset mid-access: all registers return to reset values next edge; ram_oe_n goes high; no rd_valid is produced for the aborted request.
- The block never drives writes. The write path owns the RAM write enable; no arbitration is done here.

Decomposition:
- Shared package (mem_map_pkg): SW_ADDR, STAT_ADDR, LED_ADDR (16'hBF00, used by the write path), RAM_OFFSET, and the state enum with 2-bit encoding.
- One sub-module: sw_sync_detect. It contains the 2-flop synchroniser, the sw_last register and the sticky sw_changed flag with a clear input; set has priority over clear.

Test Plan:
- Reset then idle: after rst, rd_valid=0, ram_oe_n=1, rd_data=0; all hold for 10 cycles with rd_req=0.
- RAM read: address=16'h0010, ram_data_in=16'h1234.
  - ram_addr=16'h0090.
  - ram_oe_n is low for exactly 2 cycles.
  - rd_data=16'h1234 with a single rd_valid pulse 4 cycles after acceptance.
- Offset wrap: address=16'hFFF0 -> ram_addr=16'h0070.
- Switch read: sw_in=16'hA5A5 held for 3 cycles, then read 16'hBF00 -> rd_data=16'hA5A5, rd_valid 2 cycles after acceptance.
- Status sticky/clear: toggle sw_in, read 16'hBF01 -> rd_data=16'h0001; an immediate second read -> 16'h0000.
- Busy and reset:
  - rd_req asserted in RAM_WAIT is ignored; only one rd_valid is produced.
  - rst asserted in RAM_WAIT -> ram_oe_n=1 next cycle and no rd_valid follows.
